wb_arbiter: RTL

- Two-master, one-slave Wishbone classic arbiter. It shares the system bus between the J1 CPU (m0) and a second bus master (m1), for example a USB endpoint DMA engine.
- It sits between the masters and wb_intercon, so the interconnect still sees a single master.
- Arbitration is round-robin and the bus stays locked for the whole CYC period.
- A watchdog terminates stalled cycles with ERR.

---
 rtl/wb_arbiter_pkg.sv | 21 ++
 rtl/wb_arbiter_if.sv | 17 +
 rtl/wb_arb_watchdog.sv | 36 +++
 rtl/wb_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the two-master Wishbone arbiter.
package wb_arbiter_pkg;

  localparam int ARB_NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  // One-hot grant vector for a given owner state.
  function automatic logic [ARB_NUM_MASTERS-1:0] arb_gnt(input arb_state_t st);
    case (st)
      ARB_OWN0: return 2'b01;
      ARB_OWN1: return 2'b10;
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// One Wishbone classic link; master drives the request side, slave the termination side.
interface wb_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] dat_r;
  logic              ack;
  logic              err;

  modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts un-terminated STB cycles and pulses o_timeout once TIMEOUT is reached.
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_term,
  output logic o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("wb_arb_watchdog: TIMEOUT must be at least 2");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit = (r_cnt == CNT_W'(TIMEOUT));
  // A slave termination in the timeout cycle takes priority over the forced error.
  assign o_timeout = i_active & i_stb & ~i_term & w_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_active || !i_stb || i_term || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin two-master Wishbone classic arbiter; the owner keeps the bus for its whole CYC.
//   state    | meaning
//   ARB_IDLE | no owner, slave side quiet, arbitration happens here
//   ARB_OWN0 | master 0 owns the slave bus
//   ARB_OWN1 | master 1 owns the slave bus
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  wb_arbiter_if.slave                m0,
  wb_arbiter_if.slave                m1,
  wb_arbiter_if.master               s,
  output logic [ARB_NUM_MASTERS-1:0] gnt
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_ptr;       // 0 favours m0, 1 favours m1
  logic       w_ptr_nxt;
  logic       w_active;
  logic       w_stb;
  logic       w_term;
  logic       w_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (m0.cyc && (!m1.cyc || !r_ptr)) begin
          w_state_nxt = ARB_OWN0;
          w_ptr_nxt   = 1'b1;
        end else if (m1.cyc) begin
          w_state_nxt = ARB_OWN1;
          w_ptr_nxt   = 1'b0;
        end
      end
      ARB_OWN0: if (!m0.cyc) w_state_nxt = ARB_IDLE;
      ARB_OWN1: if (!m1.cyc) w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  assign w_active = (r_state != ARB_IDLE);
  assign w_stb    = (r_state == ARB_OWN0) ? m0.stb :
                    (r_state == ARB_OWN1) ? m1.stb : 1'b0;
  assign w_term   = s.ack | s.err;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_active  (w_active),
    .i_stb     (w_stb),
    .i_term    (w_term),
    .o_timeout (w_timeout)
  );

  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.adr    = {ADDR_W{1'b0}};
    s.dat_w  = {DATA_W{1'b0}};
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.dat_r = {DATA_W{1'b0}};
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.dat_r = {DATA_W{1'b0}};
    case (r_state)
      ARB_OWN0: begin
        s.cyc    = m0.cyc;
        s.stb    = m0.stb & ~w_timeout;
        s.we     = m0.we;
        s.adr    = m0.adr;
        s.dat_w  = m0.dat_w;
        m0.ack   = s.ack;
        m0.err   = s.err | w_timeout;
        m0.dat_r = s.dat_r;
      end
      ARB_OWN1: begin
        s.cyc    = m1.cyc;
        s.stb    = m1.stb & ~w_timeout;
        s.we     = m1.we;
        s.adr    = m1.adr;
        s.dat_w  = m1.dat_w;
        m1.ack   = s.ack;
        m1.err   = s.err | w_timeout;
        m1.dat_r = s.dat_r;
      end
      default: ;
    endcase
  end

  assign gnt = arb_gnt(r_state);

endmodule
